syzygy_adc_frame_align: RTL and testbench

Parametrised frame-alignment controller for SYZYGY ADC receivers. It monitors the deserialised frame words of NUM_LANES independent frame lanes and pulses a per-lane bitslip until each lane shows FRAME_PATTERN. It declares lock only after LOCK_COUNT consecutive matches and drops lock only after LOSS_COUNT consecutive misses. It sits between the frame-lane ISERDES outputs and the data-lane ISERDES BITSLIP inputs, in the slow (CLKDIV) domain, and adds bounded retry with error reporting and a software realign request.

---
 rtl/syzygy_adc_frame_align.sv | 153 +++++++++++++++
 tb/tb_syzygy_adc_frame_align.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_adc_frame_align.sv
// Frame-alignment controller: per-lane bitslip search until the frame word matches,
// with lock/loss hysteresis, bounded retries (FAIL) and a software realign request.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_SEARCH  | compare frame word; slip on miss, fail when slip budget spent
//   S_WAIT    | SLIP_WAIT idle cycles after a bitslip, frame word ignored
//   S_CONFIRM | counting consecutive matches toward LOCK_COUNT
//   S_LOCKED  | aligned, data_valid high; counting consecutive misses
//   S_FAIL    | slip budget exhausted, error high; held until realign
module syzygy_adc_frame_align #(
    parameter int                NUM_LANES     = 1,
    parameter int                WIDTH         = 8,
    parameter logic [WIDTH-1:0]  FRAME_PATTERN = 8'b11110000,
    parameter int                SLIP_WAIT     = 3,
    parameter int                LOCK_COUNT    = 16,
    parameter int                LOSS_COUNT    = 4,
    parameter int                MAX_SLIPS     = 2 * WIDTH,
    localparam int               CW            = $clog2(MAX_SLIPS + 1)
) (
    input  logic                      slow_clk,
    input  logic                      reset_n,
    input  logic [NUM_LANES*WIDTH-1:0] frame_data,
    input  logic                      realign,
    output logic [NUM_LANES-1:0]      bitslip,
    output logic [NUM_LANES-1:0]      data_valid,
    output logic                      all_locked,
    output logic [NUM_LANES-1:0]      error,
    output logic [NUM_LANES*CW-1:0]   slip_count
);

    localparam int WCW = $clog2(SLIP_WAIT + 1);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int LCW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [2:0] {
        S_SEARCH,
        S_WAIT,
        S_CONFIRM,
        S_LOCKED,
        S_FAIL
    } state_t;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        state_t         state;
        logic [WCW-1:0] wait_cnt;
        logic [MCW-1:0] match_cnt;
        logic [LCW-1:0] miss_cnt;
        logic [CW-1:0]  slips;
        logic           slip_q;
        logic           valid_q;
        logic           error_q;
        logic           match;

        assign match = (frame_data[i*WIDTH +: WIDTH] == FRAME_PATTERN);

        always_ff @(posedge slow_clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= S_SEARCH;
                wait_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                slips     <= '0;
                slip_q    <= 1'b0;
                valid_q   <= 1'b0;
                error_q   <= 1'b0;
            end else begin
                slip_q <= 1'b0;
                if (realign) begin
                    state     <= S_SEARCH;
                    wait_cnt  <= '0;
                    match_cnt <= '0;
                    miss_cnt  <= '0;
                    slips     <= '0;
                    valid_q   <= 1'b0;
                    error_q   <= 1'b0;
                end else begin
                    case (state)
                        S_SEARCH: begin
                            if (match) begin
                                if (LOCK_COUNT == 1) begin
                                    state    <= S_LOCKED;
                                    valid_q  <= 1'b1;
                                    miss_cnt <= '0;
                                end else begin
                                    state     <= S_CONFIRM;
                                    match_cnt <= MCW'(1);
                                end
                            end else if (slips >= CW'(MAX_SLIPS)) begin
                                state   <= S_FAIL;
                                error_q <= 1'b1;
                            end else begin
                                slip_q   <= 1'b1;
                                slips    <= slips + 1'b1;
                                wait_cnt <= WCW'(SLIP_WAIT);
                                state    <= S_WAIT;
                            end
                        end
                        S_WAIT: begin
                            // down-counter: terminal count 1 means this is the last idle cycle
                            if (wait_cnt <= WCW'(1)) begin
                                wait_cnt <= '0;
                                state    <= S_SEARCH;
                            end else begin
                                wait_cnt <= wait_cnt - 1'b1;
                            end
                        end
                        S_CONFIRM: begin
                            if (match) begin
                                match_cnt <= match_cnt + 1'b1;
                                if (match_cnt + 1'b1 == MCW'(LOCK_COUNT)) begin
                                    state    <= S_LOCKED;
                                    valid_q  <= 1'b1;
                                    miss_cnt <= '0;
                                end
                            end else begin
                                match_cnt <= '0;
                                state     <= S_SEARCH;
                            end
                        end
                        S_LOCKED: begin
                            if (match) begin
                                miss_cnt <= '0;
                            end else if (miss_cnt + 1'b1 == LCW'(LOSS_COUNT)) begin
                                state     <= S_SEARCH;
                                valid_q   <= 1'b0;
                                slips     <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                        S_FAIL: begin
                            state <= S_FAIL;
                        end
                        default: begin
                            state <= S_SEARCH;
                        end
                    endcase
                end
            end
        end

        assign bitslip[i]                = slip_q;
        assign data_valid[i]             = valid_q;
        assign error[i]                  = error_q;
        assign slip_count[i*CW +: CW]    = slips;
    end

    assign all_locked = &data_valid;

endmodule

// File: tb/tb_syzygy_adc_frame_align.sv
// Bench for syzygy_adc_frame_align: four lanes driven through a rotating-word
// channel model, checked every cycle against an event-level reference model.
module tb_syzygy_adc_frame_align;
    localparam int NL = 4;
    localparam int W = 8;
    localparam int SLIP_WAIT = 3;
    localparam int LOCK_COUNT = 16;
    localparam int LOSS_COUNT = 4;
    localparam int MAX_SLIPS = 16;
    localparam int CW = 5;
    localparam logic [W-1:0] PAT = 8'hF0;

    logic              slow_clk = 1'b0;
    logic              reset_n;
    logic              realign = 1'b0;
    logic [NL*W-1:0]   frame_data;
    logic [NL-1:0]     bitslip;
    logic [NL-1:0]     data_valid;
    logic              all_locked;
    logic [NL-1:0]     error;
    logic [NL*CW-1:0]  slip_count;

    int checks = 0;
    int failures = 0;

    syzygy_adc_frame_align #(
        .NUM_LANES(NL), .WIDTH(W), .FRAME_PATTERN(PAT), .SLIP_WAIT(SLIP_WAIT),
        .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .MAX_SLIPS(MAX_SLIPS)
    ) dut (
        .slow_clk(slow_clk), .reset_n(reset_n), .frame_data(frame_data),
        .realign(realign), .bitslip(bitslip), .data_valid(data_valid),
        .all_locked(all_locked), .error(error), .slip_count(slip_count)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int r);
        logic [W-1:0] x;
        x = w;
        for (int k = 0; k < r % W; k++) x = {x[W-2:0], x[W-1]};
        return x;
    endfunction

    // Channel: each bitslip rotates the lane word left by one bit, two cycles later.
    logic [W-1:0] base[NL];
    int           rot[NL];
    bit           force_en[NL];
    logic [W-1:0] force_word[NL];
    bit           pipe0[NL];
    bit           pipe1[NL];

    always_comb begin
        frame_data = '0;
        for (int i = 0; i < NL; i++)
            frame_data[i*W +: W] = force_en[i] ? force_word[i] : rotl(base[i], rot[i]);
    end

    // Reference model: lane behaviour expressed as run lengths and a resume time.
    longint edge_n;
    int     m_slips[NL];
    int     m_run[NL];
    int     m_miss[NL];
    longint m_resume[NL];
    bit     m_locked[NL];
    bit     m_failed[NL];
    bit     m_bs[NL];

    task automatic clear_lane(input int i);
        m_slips[i] = 0; m_run[i] = 0; m_miss[i] = 0; m_resume[i] = 0;
        m_locked[i] = 0; m_failed[i] = 0; m_bs[i] = 0;
    endtask

    always @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_n = 0;
            for (int i = 0; i < NL; i++) clear_lane(i);
        end else begin
            edge_n++;
            for (int i = 0; i < NL; i++) begin
                bit m;
                m = (frame_data[i*W +: W] == PAT);
                m_bs[i] = 0;
                if (realign) begin
                    clear_lane(i);
                end else if (m_failed[i]) begin
                    m_failed[i] = 1;
                end else if (m_locked[i]) begin
                    if (m) m_miss[i] = 0;
                    else begin
                        m_miss[i]++;
                        if (m_miss[i] == LOSS_COUNT) begin
                            m_locked[i] = 0; m_slips[i] = 0; m_run[i] = 0; m_miss[i] = 0;
                        end
                    end
                end else if (edge_n < m_resume[i]) begin
                    m_run[i] = 0;
                end else if (m) begin
                    m_run[i]++;
                    if (m_run[i] == LOCK_COUNT) begin
                        m_locked[i] = 1; m_miss[i] = 0; m_run[i] = 0;
                    end
                end else if (m_run[i] > 0) begin
                    m_run[i] = 0;
                end else if (m_slips[i] == MAX_SLIPS) begin
                    m_failed[i] = 1;
                end else begin
                    m_slips[i]++;
                    m_bs[i] = 1;
                    m_resume[i] = edge_n + SLIP_WAIT + 1;
                end
            end
        end
    end

    always @(negedge slow_clk) begin
        for (int i = 0; i < NL; i++) begin
            if (pipe1[i]) rot[i]++;
            pipe1[i] = pipe0[i];
            pipe0[i] = m_bs[i];
        end
    end

    always @(negedge slow_clk) begin
        logic [NL-1:0]    e_bs, e_dv, e_err;
        logic [NL*CW-1:0] e_sc;
        e_bs = '0; e_dv = '0; e_err = '0; e_sc = '0;
        for (int i = 0; i < NL; i++) begin
            e_bs[i] = m_bs[i];
            e_dv[i] = m_locked[i];
            e_err[i] = m_failed[i];
            e_sc[i*CW +: CW] = CW'(m_slips[i]);
        end
        check("bitslip", 64'(bitslip), 64'(e_bs));
        check("data_valid", 64'(data_valid), 64'(e_dv));
        check("error", 64'(error), 64'(e_err));
        check("slip_count", 64'(slip_count), 64'(e_sc));
        check("all_locked", 64'(all_locked), 64'(&e_dv));
    end

    longint dv0_edge;
    longint last3;
    longint min_sp3;
    int     bs_cnt[NL];
    int     noise_pct[NL];
    bit     got;

    initial begin
        reset_n = 1'b1;
        for (int i = 0; i < NL; i++) begin
            rot[i] = 0; force_en[i] = 0; force_word[i] = '0; pipe0[i] = 0; pipe1[i] = 0;
            bs_cnt[i] = 0; noise_pct[i] = 0;
        end
        base[0] = 8'hF0; base[1] = 8'h1E; base[2] = 8'hE1; base[3] = 8'h00;
        #1 reset_n = 1'b0;
        #3;
        check("reset_outputs", 64'({bitslip, data_valid, error, slip_count, all_locked}), 64'd0);
        repeat (3) @(negedge slow_clk);
        reset_n = 1'b1;

        // Initial acquisition on all four lanes.
        dv0_edge = -1; last3 = -100; min_sp3 = 1000;
        for (int c = 0; c < 300 && !(error == 4'b1000 && data_valid == 4'b0111); c++) begin
            @(negedge slow_clk);
            if (data_valid[0] && dv0_edge < 0) dv0_edge = edge_n;
            for (int i = 0; i < NL; i++) if (bitslip[i]) bs_cnt[i]++;
            if (bitslip[3]) begin
                if (edge_n - last3 < min_sp3) min_sp3 = edge_n - last3;
                last3 = edge_n;
            end
        end
        check("acquire_done", 64'(error == 4'b1000 && data_valid == 4'b0111), 64'd1);
        check("lane0_lock_edge", 64'(dv0_edge), 64'd16);
        check("lane0_slips_seen", 64'(bs_cnt[0]), 64'd0);
        check("lane1_slips_seen", 64'(bs_cnt[1]), 64'd3);
        check("lane2_slips_seen", 64'(bs_cnt[2]), 64'd7);
        check("lane3_slips_seen", 64'(bs_cnt[3]), 64'd16);
        check("lane3_slip_spacing", 64'(min_sp3), 64'd4);
        check("slip_count_lanes", 64'(slip_count), 64'({5'd16, 5'd7, 5'd3, 5'd0}));
        check("all_locked_fail_lane", 64'(all_locked), 64'd0);

        // Software realign.
        realign = 1'b1;
        @(negedge slow_clk);
        realign = 1'b0;
        check("realign_clears", 64'({data_valid, error, slip_count}), 64'd0);
        repeat (20) @(negedge slow_clk);
        check("relock_after_realign", 64'(data_valid), 64'(4'b0111));
        check("lane3_searching", 64'(error), 64'd0);

        // Lock hysteresis on lane 0: 3 misses, 1 match, 4 misses.
        force_word[0] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            force_en[0] = 1;
            @(negedge slow_clk);
            check("hyst_burst1", 64'(data_valid[0]), 64'd1);
        end
        force_en[0] = 0;
        @(negedge slow_clk);
        check("hyst_match", 64'(data_valid[0]), 64'd1);
        force_en[0] = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge slow_clk);
            check("hyst_burst2", 64'(data_valid[0]), (k < 3) ? 64'd1 : 64'd0);
        end
        check("hyst_slip_restart", 64'(slip_count[0 +: CW]), 64'd0);
        force_en[0] = 0;

        // Asynchronous reset right after a lane-3 bitslip.
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge slow_clk);
            if (bitslip[3]) got = 1;
        end
        check("wait_lane3_slip", 64'(got), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({bitslip, data_valid, error, slip_count, all_locked}), 64'd0);
        @(negedge slow_clk);
        reset_n = 1'b1;
        #1;
        check("post_reset_slips", 64'(slip_count), 64'd0);
        @(negedge slow_clk);
        check("post_reset_search_slip", 64'(bitslip[3]), 64'd1);
        check("post_reset_slip_count", 64'(slip_count[3*CW +: CW]), 64'd1);

        // Randomized episodes: aligned/misaligned/never-aligning words, noise, realigns.
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < NL; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    base[i] = rotl(PAT, int'($urandom_range(0, 7)));
                    2:       base[i] = W'($urandom);
                    default: base[i] = 8'hAA;
                endcase
                case ($urandom_range(0, 2))
                    0:       noise_pct[i] = 0;
                    1:       noise_pct[i] = 3;
                    default: noise_pct[i] = 20;
                endcase
            end
            for (int c = 0; c < 100; c++) begin
                @(negedge slow_clk);
                realign = ($urandom_range(0, 299) == 0);
                for (int i = 0; i < NL; i++) begin
                    force_en[i] = ($urandom_range(0, 99) < noise_pct[i]);
                    force_word[i] = W'($urandom);
                end
            end
        end
        realign = 1'b0;
        for (int i = 0; i < NL; i++) force_en[i] = 0;
        repeat (5) @(negedge slow_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
